// File: rtl/dsp_pkg.sv
// Shared constants and types for the DSP voice key-on/key-off sequencing logic.
package dsp_pkg;

  localparam int NUM_VOICES_DEF = 8;
  localparam int KON_DELAY_DEF  = 5;
  localparam int CTR_W          = 3;

  localparam logic [7:0] REG_KON  = 8'h4C;
  localparam logic [7:0] REG_KOFF = 8'h5C;
  localparam logic [7:0] REG_ENDX = 8'h7C;

  // Sample ticks alternate between a skip phase and a poll phase.
  typedef enum logic {
    PHASE_SKIP = 1'b0,
    PHASE_POLL = 1'b1
  } poll_phase_e;

endpackage

// File: rtl/key_delay_ctr.sv
// Per-voice key-on delay: holds busy while the envelope/BRR must stay frozen.
// Latency: busy rises 2 cycles after load and drops 1 cycle after the count reaches 0.
// Backpressure: none; load always wins over a same-cycle tick.
module key_delay_ctr
  import dsp_pkg::*;
#(
  parameter int DELAY = KON_DELAY_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic busy
);

  logic [CTR_W-1:0] ctr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr  <= '0;
      busy <= 1'b0;
    end else begin
      if (load)
        ctr <= CTR_W'(DELAY);
      else if (tick && (ctr != '0))
        ctr <= ctr - 1'b1;
      busy <= (ctr != '0);
    end
  end

endmodule

// File: rtl/dsp_key_scheduler.sv
// Latches KON/KOFF/ENDX writes and polls them every second sample tick into key pulses.
// Latency: key_on/key_off are registered one cycle after the poll cycle, 1-cycle wide.
// Backpressure: none; CPU writes between polls accumulate, a write on the poll cycle waits.
module dsp_key_scheduler
  import dsp_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int KON_DELAY  = KON_DELAY_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_en,
  input  logic                  exe_32khz,
  input  logic                  kon_wr,
  input  logic                  koff_wr,
  input  logic                  endx_wr,
  input  logic [NUM_VOICES-1:0] wdata,
  input  logic                  flg_reset,
  input  logic [NUM_VOICES-1:0] brr_end,
  output logic [NUM_VOICES-1:0] key_on,
  output logic [NUM_VOICES-1:0] key_off,
  output logic [NUM_VOICES-1:0] env_stop,
  output logic [NUM_VOICES-1:0] endx
);

  poll_phase_e           phase, phase_nxt;
  logic                  tick, poll;
  logic [NUM_VOICES-1:0] flg_mask, kon_pend, koff_reg;
  logic [NUM_VOICES-1:0] key_on_now, key_off_now;

  assign tick = cpu_en & exe_32khz;
  assign poll = tick & (phase == PHASE_POLL);

  always_comb begin
    phase_nxt = phase;
    if (tick)
      phase_nxt = (phase == PHASE_POLL) ? PHASE_SKIP : PHASE_POLL;
  end

  // Soft reset forces key-off on every voice and discards pending key-ons.
  assign flg_mask    = {NUM_VOICES{flg_reset}};
  assign key_on_now  = kon_pend & ~flg_mask;
  assign key_off_now = (koff_reg | flg_mask) & ~key_on_now;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= PHASE_SKIP;
      kon_pend <= '0;
      koff_reg <= '0;
      key_on   <= '0;
      key_off  <= '0;
      endx     <= '0;
    end else begin
      phase    <= phase_nxt;
      kon_pend <= (poll ? '0 : kon_pend) | (kon_wr ? wdata : '0);
      if (koff_wr)
        koff_reg <= wdata;
      key_on   <= poll ? key_on_now  : '0;
      key_off  <= poll ? key_off_now : '0;
      // Key-on clear beats a same-cycle BRR end; a CPU write clears everything.
      if (endx_wr)
        endx <= '0;
      else
        endx <= (endx | (cpu_en ? brr_end : '0)) & ~key_on;
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    key_delay_ctr #(
      .DELAY(KON_DELAY)
    ) u_delay (
      .clk  (clk),
      .reset(reset),
      .load (key_on[v]),
      .tick (tick),
      .busy (env_stop[v])
    );
  end

endmodule
